// File: rtl/keycode_event_ctrl_if.sv
// Event delivery interface between keycode_event_ctrl and its consumer.
//
// The producer (master) presents the head of its event FIFO. The consumer
// (slave) accepts the head by raising evt_ready while evt_valid is high.
//
//   evt_valid  master->slave  head entry holds an event
//   evt_ready  slave->master  consumer takes the head event this cycle
//   evt_code   master->slave  keycode of the head event
//   evt_type   master->slave  00 press, 01 release, 10 repeat
//   evt_count  master->slave  number of events currently buffered
interface keycode_event_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CNTF_W = $clog2(FIFO_DEPTH) + 1;

    logic              evt_valid;
    logic              evt_ready;
    logic [7:0]        evt_code;
    logic [1:0]        evt_type;
    logic [CNTF_W-1:0] evt_count;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_type,
        output evt_count,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_type,
        input  evt_count,
        output evt_ready
    );
endinterface

// File: rtl/keycode_event_ctrl.sv
// Keycode event controller.
//
// Watches the 8-bit keycode level written by the keyboard driver and turns
// each level change into press / release / typematic-repeat events. Events
// are buffered in a small first-word-fall-through FIFO and handed to the
// consumer over the valid/ready interface. Keycode 0x00 means no key held.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   keycode_in  keycode level, synchronous to clk
//   enable      1 = generate events, 0 = tracking idle (FIFO still drains)
//   clear_ovf   single-cycle pulse clearing the overflow flag
//   held        a nonzero keycode is currently tracked
//   overflow    sticky: an event was dropped because the FIFO was full
//   evt         event interface (master side): valid/ready/code/type/count
module keycode_event_ctrl #(
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int CNT_W         = 25,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [7:0]      keycode_in,
    input  logic            enable,
    input  logic            clear_ovf,
    output logic            held,
    output logic            overflow,
    keycode_event_if.master evt
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNTF_W = PTR_W + 1;

    localparam logic [1:0]        EVT_PRESS   = 2'b00;
    localparam logic [1:0]        EVT_RELEASE = 2'b01;
    localparam logic [1:0]        EVT_REPEAT  = 2'b10;
    localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0]  PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [PTR_W-1:0]  PTR_ZERO    = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE     = PTR_W'(1);
    localparam logic [CNTF_W-1:0] CNTF_ZERO   = {CNTF_W{1'b0}};
    localparam logic [CNTF_W-1:0] CNTF_ONE    = CNTF_W'(1);
    localparam logic [CNTF_W-1:0] CNTF_FULL   = CNTF_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PEND_PRESS = 2'd1,
        ST_DELAY      = 2'd2,
        ST_REPEAT     = 2'd3
    } state_t;

    // FIFO entries are stored as {type, code}.
    function automatic logic [9:0] pack_evt(input logic [1:0] ev_type, input logic [7:0] code);
        return {ev_type, code};
    endfunction

    logic [7:0]        kc_q;
    logic [7:0]        prev_code_q, prev_code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    state_t            state_q, state_d;

    logic              push_s;
    logic [9:0]        push_ev_s;
    logic              zero_s, same_s, delay_done_s, period_done_s;

    logic [9:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTF_W-1:0] count_q, count_d;
    logic [9:0]        head_q, head_d;
    logic              valid_q, valid_d;
    logic              held_q, held_d;
    logic              ovf_q, ovf_d;
    logic              full_s, wr_en_s, drop_s, pop_s;

    assign zero_s        = (kc_q == 8'h00);
    assign same_s        = (kc_q == prev_code_q);
    assign delay_done_s  = (cnt_q == DELAY_LAST);
    assign period_done_s = (cnt_q == PERIOD_LAST);

    // Input register: every decision compares this registered level with prev_code.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kc_q <= 8'h00;
        end else begin
            kc_q <= keycode_in;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; enable low parks the tracker in IDLE.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!zero_s) begin
                        state_d = ST_DELAY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PEND_PRESS: begin
                    state_d = ST_DELAY;
                end
                ST_DELAY, ST_REPEAT: begin
                    if (zero_s) begin
                        state_d = ST_IDLE;
                    end else if (!same_s) begin
                        state_d = ST_PEND_PRESS;
                    end else if ((state_q == ST_DELAY) && delay_done_s) begin
                        state_d = ST_REPEAT;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM output logic: event push, tracked code and repeat counter updates.
    always_comb begin
        push_s      = 1'b0;
        push_ev_s   = 10'h000;
        prev_code_d = prev_code_q;
        cnt_d       = cnt_q;
        if (!enable) begin
            // Disabling forgets the held key silently; no release is emitted.
            prev_code_d = 8'h00;
            cnt_d       = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!zero_s) begin
                        push_s      = 1'b1;
                        push_ev_s   = pack_evt(EVT_PRESS, kc_q);
                        prev_code_d = kc_q;
                        cnt_d       = CNT_ZERO;
                    end else begin
                        cnt_d       = cnt_q;
                    end
                end
                ST_PEND_PRESS: begin
                    // The new code was latched with the release; kc_q is ignored here.
                    push_s    = 1'b1;
                    push_ev_s = pack_evt(EVT_PRESS, prev_code_q);
                    cnt_d     = CNT_ZERO;
                end
                ST_DELAY, ST_REPEAT: begin
                    if (zero_s) begin
                        push_s      = 1'b1;
                        push_ev_s   = pack_evt(EVT_RELEASE, prev_code_q);
                        prev_code_d = 8'h00;
                    end else if (!same_s) begin
                        // Direct switch: release the old key now, press the new one next cycle.
                        push_s      = 1'b1;
                        push_ev_s   = pack_evt(EVT_RELEASE, prev_code_q);
                        prev_code_d = kc_q;
                    end else if (((state_q == ST_DELAY) && delay_done_s) ||
                                 ((state_q == ST_REPEAT) && period_done_s)) begin
                        push_s    = 1'b1;
                        push_ev_s = pack_evt(EVT_REPEAT, prev_code_q);
                        cnt_d     = CNT_ZERO;
                    end else begin
                        cnt_d     = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    prev_code_d = 8'h00;
                    cnt_d       = CNT_ZERO;
                end
            endcase
        end
    end

    assign held_d = (prev_code_d != 8'h00);

    // Tracked-key registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_code_q <= 8'h00;
            cnt_q       <= CNT_ZERO;
            held_q      <= 1'b0;
        end else begin
            prev_code_q <= prev_code_d;
            cnt_q       <= cnt_d;
            held_q      <= held_d;
        end
    end

    // Full is judged before the same-cycle pop, so a push into a full FIFO drops.
    assign full_s  = (count_q == CNTF_FULL);
    assign wr_en_s = push_s & ~full_s;
    assign drop_s  = push_s & full_s;
    assign pop_s   = valid_q & evt.evt_ready;

    // FIFO next-state: pointers, occupancy, registered head and overflow flag.
    always_comb begin
        wr_ptr_d = wr_en_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + CNTF_ONE;
            2'b01:   count_d = count_q - CNTF_ONE;
            default: count_d = count_q;
        endcase
        valid_d = (count_d != CNTF_ZERO);
        // The next head may be the entry being written this very cycle.
        if (!valid_d) begin
            head_d = 10'h000;
        end else if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_ev_s;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // FIFO storage and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 10'h000;
            end
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNTF_ZERO;
            head_q   <= 10'h000;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_q[wr_ptr_q] <= push_ev_s;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign evt.evt_valid = valid_q;
    assign evt.evt_code  = head_q[7:0];
    assign evt.evt_type  = head_q[9:8];
    assign evt.evt_count = count_q;
    assign held          = held_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_keycode_event_ctrl.sv
// Testbench for keycode_event_ctrl: table-driven vectors, hand-written
// sequences for the multi-cycle corner cases, and randomized stimulus, all
// checked every cycle against a reference model built from absolute repeat
// deadlines and an event queue.
module tb_keycode_event_ctrl;

    localparam int RD    = 10;
    localparam int RP    = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] kc_in;
    logic       enable;
    logic       clear_ovf;
    logic       held;
    logic       overflow;

    always #5 clk = ~clk;

    keycode_event_if #(.FIFO_DEPTH(DEPTH)) bus ();

    keycode_event_ctrl #(
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .CNT_W        (8),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .keycode_in(kc_in),
        .enable    (enable),
        .clear_ovf (clear_ovf),
        .held      (held),
        .overflow  (overflow),
        .evt       (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [9:0] mq[$];          // {type, code}
    logic [7:0] m_kc;           // level seen by the controller this cycle
    logic [7:0] m_track;        // tracked key, 0 = none
    bit         m_pend;         // press for m_track still owed
    bit         m_ovf;
    longint     m_t;
    longint     m_deadline;     // absolute cycle of the next repeat

    task automatic model_reset();
        mq.delete();
        m_kc = 8'h00; m_track = 8'h00; m_pend = 1'b0; m_ovf = 1'b0; m_deadline = 0;
    endtask

    task automatic model_step();
        bit         push;
        bit         full;
        logic [9:0] ev;
        push = 1'b0;
        ev   = 10'h000;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (!enable) begin
            m_track = 8'h00;
            m_pend  = 1'b0;
        end else if (m_pend) begin
            push = 1'b1; ev = {2'b00, m_track}; m_deadline = m_t + RD; m_pend = 1'b0;
        end else if (m_track == 8'h00) begin
            if (m_kc != 8'h00) begin
                push = 1'b1; ev = {2'b00, m_kc}; m_track = m_kc; m_deadline = m_t + RD;
            end
        end else if (m_kc == m_track) begin
            if (m_t == m_deadline) begin
                push = 1'b1; ev = {2'b10, m_track}; m_deadline = m_t + RP;
            end
        end else if (m_kc == 8'h00) begin
            push = 1'b1; ev = {2'b01, m_track}; m_track = 8'h00;
        end else begin
            push = 1'b1; ev = {2'b01, m_track}; m_track = m_kc; m_pend = 1'b1;
        end
        full = (mq.size() == DEPTH);
        if (mq.size() > 0 && bus.evt_ready) void'(mq.pop_front());
        if (push) begin
            if (full) m_ovf = 1'b1;
            else mq.push_back(ev);
        end
        if (clear_ovf && !(push && full)) m_ovf = 1'b0;
        m_kc = kc_in;
        m_t++;
    endtask

    task automatic compare_model();
        chk("model_valid", int'(bus.evt_valid), int'(mq.size() != 0));
        chk("model_count", int'(bus.evt_count), mq.size());
        if (mq.size() != 0) begin
            chk("model_code", int'(bus.evt_code), int'(mq[0][7:0]));
            chk("model_type", int'(bus.evt_type), int'(mq[0][9:8]));
        end
        chk("model_held", int'(held), int'(m_track != 8'h00));
        chk("model_ovf", int'(overflow), int'(m_ovf));
    endtask

    // Pops seen by the consumer, by type.
    int n_pr, n_rl, n_rp;

    // One clock: note the pop about to happen, advance model, sample #1 later.
    task automatic step();
        if (bus.evt_valid && bus.evt_ready) begin
            case (bus.evt_type)
                2'b00:   n_pr++;
                2'b01:   n_rl++;
                2'b10:   n_rp++;
                default: n_rp = n_rp + 100;
            endcase
        end
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [7:0] kc;
        logic       rdy;
        logic       e_valid;
        logic [7:0] e_code;
        logic [1:0] e_type;
        int         e_count;
        logic       e_held;
    } vec_t;

    vec_t       tv[13];
    logic [9:0] got[4];
    logic [9:0] exp_ord[4];
    bit         saw_ovf;

    initial begin
        // Tap, then a direct switch under backpressure.
        tv[0]  = '{8'h04, 1'b1, 1'b0, 8'h00, 2'd0, 0, 1'b0};
        tv[1]  = '{8'h04, 1'b1, 1'b1, 8'h04, 2'd0, 1, 1'b1};
        tv[2]  = '{8'h04, 1'b1, 1'b0, 8'h00, 2'd0, 0, 1'b1};
        tv[3]  = '{8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 0, 1'b1};
        tv[4]  = '{8'h00, 1'b1, 1'b1, 8'h04, 2'd1, 1, 1'b0};
        tv[5]  = '{8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 0, 1'b0};
        tv[6]  = '{8'h05, 1'b0, 1'b0, 8'h00, 2'd0, 0, 1'b0};
        tv[7]  = '{8'h06, 1'b0, 1'b1, 8'h05, 2'd0, 1, 1'b1};
        tv[8]  = '{8'h06, 1'b0, 1'b1, 8'h05, 2'd0, 2, 1'b1};
        tv[9]  = '{8'h06, 1'b1, 1'b1, 8'h05, 2'd1, 2, 1'b1};
        tv[10] = '{8'h00, 1'b1, 1'b1, 8'h06, 2'd0, 1, 1'b1};
        tv[11] = '{8'h00, 1'b1, 1'b1, 8'h06, 2'd1, 1, 1'b0};
        tv[12] = '{8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 0, 1'b0};

        reset_n = 1'b0; kc_in = 8'h00; enable = 1'b1; clear_ovf = 1'b0; bus.evt_ready = 1'b1;
        m_t = 0; n_pr = 0; n_rl = 0; n_rp = 0;
        model_reset();
        steps(3);
        chk("rst_valid", int'(bus.evt_valid), 0);
        chk("rst_count", int'(bus.evt_count), 0);
        chk("rst_code", int'(bus.evt_code), 0);
        chk("rst_type", int'(bus.evt_type), 0);
        chk("rst_held", int'(held), 0);
        chk("rst_ovf", int'(overflow), 0);
        reset_n = 1'b1;
        steps(2);

        for (int i = 0; i < 13; i++) begin
            kc_in = tv[i].kc;
            bus.evt_ready = tv[i].rdy;
            step();
            chk($sformatf("vec%0d_valid", i), int'(bus.evt_valid), int'(tv[i].e_valid));
            chk($sformatf("vec%0d_count", i), int'(bus.evt_count), tv[i].e_count);
            chk($sformatf("vec%0d_held", i), int'(held), int'(tv[i].e_held));
            if (tv[i].e_valid) begin
                chk($sformatf("vec%0d_code", i), int'(bus.evt_code), int'(tv[i].e_code));
                chk($sformatf("vec%0d_type", i), int'(bus.evt_type), int'(tv[i].e_type));
            end
        end
        steps(2);

        // Hold 0x1A for 30 cycles: 1 press, 5 repeats, 1 release.
        n_pr = 0; n_rl = 0; n_rp = 0;
        kc_in = 8'h1A; steps(30);
        kc_in = 8'h00; steps(6);
        chk("hold_press", n_pr, 1);
        chk("hold_repeat", n_rp, 5);
        chk("hold_release", n_rl, 1);

        // Direct switch after repeats started; timer restarts for the new key.
        kc_in = 8'h04; steps(15);
        kc_in = 8'h05; steps(20);
        kc_in = 8'h00; steps(4);

        // Backpressure: six events into a four-entry FIFO.
        bus.evt_ready = 1'b0;
        kc_in = 8'h04; steps(2);
        kc_in = 8'h05; steps(3);
        kc_in = 8'h00; steps(2);
        kc_in = 8'h06; steps(2);
        kc_in = 8'h00; steps(3);
        chk("bp_count", int'(bus.evt_count), 4);
        chk("bp_ovf", int'(overflow), 1);
        clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
        chk("bp_clear", int'(overflow), 0);
        // Clear held high across further drops: the set must still show.
        saw_ovf = 1'b0;
        clear_ovf = 1'b1;
        kc_in = 8'h07;
        for (int i = 0; i < 3; i++) begin step(); saw_ovf |= overflow; end
        kc_in = 8'h00;
        for (int i = 0; i < 3; i++) begin step(); saw_ovf |= overflow; end
        clear_ovf = 1'b0; step();
        chk("bp_set_wins", int'(saw_ovf), 1);
        exp_ord[0] = {2'b00, 8'h04}; exp_ord[1] = {2'b01, 8'h04};
        exp_ord[2] = {2'b00, 8'h05}; exp_ord[3] = {2'b01, 8'h05};
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            got[i] = {bus.evt_type, bus.evt_code};
            step();
        end
        for (int i = 0; i < 4; i++) chk($sformatf("bp_order%0d", i), int'(got[i]), int'(exp_ord[i]));
        chk("bp_drained", int'(bus.evt_count), 0);

        // Enable drop while 0x2C is held.
        kc_in = 8'h2C; steps(4);
        n_rl = 0;
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("dis_held", int'(held), 0);
        end
        chk("dis_no_release", n_rl, 0);
        enable = 1'b1; step();
        chk("reen_valid", int'(bus.evt_valid), 1);
        chk("reen_code", int'(bus.evt_code), 8'h2C);
        chk("reen_type", int'(bus.evt_type), 0);
        kc_in = 8'h00; steps(6);

        // Asynchronous reset during REPEAT with two events queued.
        bus.evt_ready = 1'b0;
        kc_in = 8'h1A; steps(14);
        chk("mr_queued", int'(bus.evt_count), 2);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        chk("mr_valid", int'(bus.evt_valid), 0);
        chk("mr_count", int'(bus.evt_count), 0);
        chk("mr_code", int'(bus.evt_code), 0);
        chk("mr_type", int'(bus.evt_type), 0);
        chk("mr_held", int'(held), 0);
        chk("mr_ovf", int'(overflow), 0);
        steps(2);
        reset_n = 1'b1;
        steps(2);
        chk("mr_fresh_valid", int'(bus.evt_valid), 1);
        chk("mr_fresh_code", int'(bus.evt_code), 8'h1A);
        chk("mr_fresh_type", int'(bus.evt_type), 0);
        bus.evt_ready = 1'b1;
        kc_in = 8'h00; steps(4);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 23) == 0) begin
                case ($urandom_range(0, 4))
                    0, 1:    kc_in = 8'h00;
                    2:       kc_in = 8'h04;
                    3:       kc_in = 8'h05;
                    default: kc_in = 8'h1A;
                endcase
            end
            if ((i / 200) % 2 == 1) bus.evt_ready = ($urandom_range(0, 7) == 0);
            else bus.evt_ready = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 99) != 0);
            clear_ovf = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keycode_event_ctrl.md
Name: keycode_event_ctrl

Overview:
- Sequences the 8-bit keycode level driven by the keycode PIO register (written by the Nios II USB keyboard driver).
- Converts each level change into discrete press, release and typematic-repeat events.
- Buffers events in a small FIFO and delivers them to the text-mode graphics consumer over a valid/ready handshake.
- Keycode 0x00 means "no key held".

Parameters:
- REPEAT_DELAY, 25000000, cycles from press event to first repeat event (500 ms at 50 MHz); must be >= 2
- REPEAT_PERIOD, 5000000, cycles between successive repeat events (100 ms at 50 MHz); must be >= 2
- CNT_W, 25, counter width; must hold max(REPEAT_DELAY, REPEAT_PERIOD) - 1
- FIFO_DEPTH, 4, event FIFO entries; power of two, >= 2

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- keycode_in  in  8  keycode level from PIO out_port; synchronous to clk
- enable  in  1  1 = generate events; 0 = controller idle
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts head event this cycle
- evt_code  out  8  keycode of head event
- evt_type  out  2  00 press, 01 release, 10 repeat; 11 never produced
- evt_count  out  log2(FIFO_DEPTH)+1  events currently buffered
- held  out  1  a nonzero keycode is currently tracked
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- clear_ovf  in  1  single-cycle pulse clears overflow

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk.
  - Outputs: evt_valid=0, evt_code=0, evt_type=0, evt_count=0, held=0, overflow=0.
  - Internal: kc_q=0, prev_code=0, counter=0, FIFO empty, FSM=IDLE.
- Input register: kc_q <= keycode_in every cycle. All decisions use kc_q versus prev_code.
- Latency: keycode_in changes before edge E0; kc_q updates at E0; the event is pushed at E1; evt_valid=1 after E1 if the FIFO was empty (2 cycles).
- FSM states: IDLE, PEND_PRESS, DELAY, REPEAT. held = (prev_code != 0).
  - IDLE: if kc_q != 0, push press(kc_q), prev_code <= kc_q, counter <= 0, go DELAY.
  - DELAY or REPEAT, kc_q == prev_code:
    - counter increments.
    - In DELAY, when counter == REPEAT_DELAY-1: push repeat(prev_code), counter <= 0, go REPEAT.
    - In REPEAT, when counter == REPEAT_PERIOD-1: push repeat(prev_code), counter <= 0.
  - DELAY or REPEAT, kc_q == 0: push release(prev_code), prev_code <= 0, go IDLE.
  - DELAY or REPEAT, kc_q nonzero and != prev_code: push release(prev_code), latch new code into prev_code, go PEND_PRESS.
  - PEND_PRESS (exactly 1 cycle): push press(prev_code), counter <= 0, go DELAY. kc_q is not examined this cycle.
    - A change during that cycle is handled on the following cycle.
    - A return to 0 during that cycle produces release(prev_code) on the following cycle.
- Release always precedes the next press in FIFO order.
- At most one push per cycle.
- enable=0:
  - FSM forced to IDLE, prev_code <= 0, counter <= 0, no pushes; no release is generated for a held key.
  - The FIFO continues to drain.
  - When enable returns to 1 with kc_q != 0, a press is generated from IDLE.
- FIFO:
  - First-word-fall-through; evt_code/evt_type are registered FIFO head outputs, valid whenever evt_valid=1.
  - Pop occurs when evt_valid && evt_ready at the clock edge.
  - Full is evaluated before the same-cycle pop: a push while full is dropped and sets overflow, even if a pop occurs in that cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps evt_count unchanged.
  - evt_ready while empty has no effect.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- overflow: set on a dropped push; cleared by clear_ovf. Set wins if both occur in the same cycle.
- Counter never exceeds its terminal value; it does not wrap.

Test Plan (REPEAT_DELAY=10, REPEAT_PERIOD=4, FIFO_DEPTH=4, evt_ready=1 unless stated):
- Tap: keycode_in 0x00->0x04 for 3 cycles->0x00.
  - Required: press(0x04) with evt_valid 2 cycles after the change, then release(0x04).
  - No repeat; held=1 only while tracked.
- Hold: keycode_in=0x1A for 30 cycles.
  - Required: press, first repeat 10 cycles after the press push, then repeats every 4 cycles (5 repeats total), then release on 0x00.
- Direct switch: 0x04 held, then 0x05 with no intervening 0.
  - Required: release(0x04) then press(0x05) on consecutive cycles; the repeat timer restarts for 0x05.
- Backpressure/overflow: evt_ready=0, generate 6 events.
  - Required: evt_count saturates at 4, overflow=1, FIFO holds the first 4 events in order.
  - clear_ovf pulse -> overflow=0.
  - clear_ovf in the same cycle as a drop -> overflow stays 1.
- Enable drop: hold 0x2C, deassert enable for 5 cycles, reassert.
  - Required: no release while disabled, held=0, then a new press(0x2C) 1 cycle after enable returns.
- Reset mid-repeat: assert reset_n=0 asynchronously during the REPEAT state with 2 events queued.
  - Required: all outputs 0 immediately, FIFO empty; after release, a still-held key produces a fresh press.
